// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for the instruction fetch unit: instruction memory read port
// plus the fetch-to-decode valid/ready channel and the redirect inputs.
interface instr_fetch_unit_if;
  // Instruction memory read port
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  // Fetch-to-decode channel
  logic        if_valid;
  logic [31:0] if_instr;
  logic [5:0]  if_opcode;
  logic [31:0] if_pc_plus4;
  logic        id_ready;

  // Redirect requests from decode and execute
  logic        jump;
  logic        branch_taken;
  logic [31:0] branch_target;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_opcode, if_pc_plus4,
    input  imem_rvalid, imem_rdata, id_ready, jump, branch_taken, branch_target
  );

  // Memory / decode / execute side
  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_opcode, if_pc_plus4,
    output imem_rvalid, imem_rdata, id_ready, jump, branch_taken, branch_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one instruction memory read
// at a time and hands each fetched word (with opcode and PC+4) to decode.
// Jumps and taken branches redirect the PC and discard any fetch in flight.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               arst_n,
  instr_fetch_unit_if.master bus
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  typedef enum logic [1:0] {
    S_FETCH,  // free to issue a request
    S_WAIT,   // one request outstanding, data will be kept
    S_FLUSH   // one request outstanding, data will be dropped
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic        valid_q;
  logic [31:0] instr_q;
  logic [31:0] pc_plus4_q;

  logic        redirect;
  logic [31:0] target_raw;
  logic [31:0] target;
  logic        handshake;
  logic        req;
  logic [31:0] pc_plus4_d;

  // Redirect decision and next-fetch request; branch has priority over jump.
  // The raw target is masked rather than sliced so the ignored low bits of
  // the branch target still participate in the expression.
  always_comb begin
    redirect   = bus.branch_taken || (bus.jump && valid_q);
    target_raw = bus.branch_taken ? bus.branch_target
                                  : {pc_plus4_q[31:28], instr_q[25:0], 2'b00};
    target     = target_raw & 32'hFFFF_FFFC;
    handshake  = valid_q && bus.id_ready;
    req        = (state_q == S_FETCH) && (!valid_q || bus.id_ready) && !redirect;
    pc_plus4_d = pc_q + 32'd4;
  end

  // Fetch sequencer: PC, state and the single-entry output register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC_ALIGNED;
      valid_q    <= 1'b0;
      instr_q    <= '0;
      pc_plus4_q <= '0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (redirect) begin
            pc_q    <= target;
            valid_q <= 1'b0;
          end else begin
            if (handshake) begin
              valid_q <= 1'b0;
            end
            if (req) begin
              state_q <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (redirect) begin
            // Data returning on this same edge is stale: drop it and go
            // straight back to fetching; otherwise wait it out in FLUSH.
            pc_q    <= target;
            valid_q <= 1'b0;
            state_q <= bus.imem_rvalid ? S_FETCH : S_FLUSH;
          end else if (bus.imem_rvalid) begin
            instr_q    <= bus.imem_rdata;
            pc_plus4_q <= pc_plus4_d;
            pc_q       <= pc_plus4_d;
            valid_q    <= 1'b1;
            state_q    <= S_FETCH;
          end else if (handshake) begin
            valid_q <= 1'b0;
          end
        end

        S_FLUSH: begin
          if (redirect) begin
            pc_q    <= target;
            valid_q <= 1'b0;
          end else if (handshake) begin
            valid_q <= 1'b0;
          end
          if (bus.imem_rvalid) begin
            state_q <= S_FETCH;
          end
        end

        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = valid_q;
  assign bus.if_instr    = instr_q;
  assign bus.if_opcode   = instr_q[31:26];
  assign bus.if_pc_plus4 = pc_plus4_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_instr_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic clk = 1'b0;
  logic arst_n = 1'b1;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .arst_n(arst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: PC, one output slot, an outstanding-request flag and a
  // flag saying the outstanding response must be thrown away.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  bit          m_valid;
  bit          m_busy;
  bit          m_drop;

  // Memory responder
  int unsigned mem_cnt;
  logic [31:0] mem_data;
  int unsigned k_lo;
  int unsigned k_hi;
  bit          force_en;
  logic [31:0] force_val;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RST_PC;
    m_instr = '0;
    m_pc4   = '0;
    m_valid = 1'b0;
    m_busy  = 1'b0;
    m_drop  = 1'b0;
    mem_cnt = 0;
  endtask

  // Reset outputs are checked combinationally while reset is held.
  task automatic apply_reset();
    arst_n = 1'b0;
    #1;
    chk("rst_valid", bus.if_valid, 1'b0);
    chk("rst_instr", bus.if_instr, 32'h0);
    chk("rst_pc4",   bus.if_pc_plus4, 32'h0);
    chk("rst_addr",  bus.imem_addr, RST_PC);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, check against the model, clock, update.
  // Called at 1 time unit after a rising edge.
  task automatic step(input bit rdy, input bit jmp, input bit bt, input logic [31:0] tgt);
    bit          rv;
    bit          redir;
    bit          e_req;
    bit          hs;
    bit          load;
    logic [31:0] raw;
    logic [31:0] targ;

    bus.id_ready      = rdy;
    bus.jump          = jmp;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    rv = (mem_cnt == 1);
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? mem_data : $urandom;
    #1;

    redir = bt || (jmp && m_valid);
    raw   = bt ? tgt : {m_pc4[31:28], m_instr[25:0], 2'b00};
    targ  = {raw[31:2], 2'b00};
    e_req = !m_busy && (!m_valid || rdy) && !redir;

    chk("imem_req", bus.imem_req, e_req);
    if (e_req) chk("imem_addr", bus.imem_addr, m_pc);
    chk("if_valid", bus.if_valid, m_valid);
    if (m_valid) begin
      chk("if_instr",    bus.if_instr, m_instr);
      chk("if_pc_plus4", bus.if_pc_plus4, m_pc4);
      chk("if_opcode",   bus.if_opcode, {26'h0, m_instr[31:26]});
    end

    @(posedge clk);

    hs   = m_valid && rdy;
    load = m_busy && rv && !m_drop && !redir;
    if (m_busy && rv) begin
      m_busy = 1'b0;
      m_drop = 1'b0;
    end
    if (load) begin
      m_instr = mem_data;
      m_pc    = m_pc + 32'd4;
      m_pc4   = m_pc;
      m_valid = 1'b1;
    end else if (hs) begin
      m_valid = 1'b0;
    end
    if (redir) begin
      m_pc    = targ;
      m_valid = 1'b0;
      if (m_busy) m_drop = 1'b1;
    end
    if (e_req) m_busy = 1'b1;

    if (rv) mem_cnt = 0;
    else if (mem_cnt > 1) mem_cnt--;
    if (e_req) begin
      mem_cnt  = $urandom_range(k_hi, k_lo);
      mem_data = force_en ? force_val : $urandom;
      force_en = 1'b0;
    end
    #1;
  endtask

  // Stall decode until an instruction is presented (bounded).
  task automatic wait_valid();
    int unsigned n = 0;
    while (!m_valid && n < 20) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      n++;
    end
    if (!m_valid) chk("wait_valid_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    bus.id_ready      = 1'b0;
    bus.jump          = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.imem_rvalid   = 1'b0;
    bus.imem_rdata    = '0;
    force_en  = 1'b0;
    force_val = '0;
    mem_data  = '0;
    k_lo = 1;
    k_hi = 1;
    model_reset();
    #2;
    apply_reset();

    // Streaming with single-cycle memory and decode always ready
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'h0);

    // Backpressure: hold decode off for four cycles, then release
    wait_valid();
    repeat (4) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      chk("bp_no_req", bus.imem_req, 1'b0);
    end
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Jump from a known instruction at 0x0040_000C
    wait_valid();
    step(1'b1, 1'b0, 1'b1, 32'h0040_000C);
    force_en  = 1'b1;
    force_val = 32'h0810_0004;
    wait_valid();
    chk("jmp_instr", bus.if_instr, 32'h0810_0004);
    chk("jmp_pc4",   bus.if_pc_plus4, 32'h0040_0010);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("jmp_addr",  bus.imem_addr, 32'h0040_0010);
    chk("jmp_drop",  bus.if_valid, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    wait_valid();

    // Branch while waiting on a 3-cycle memory
    k_lo = 3;
    k_hi = 3;
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
    chk("br_addr", bus.imem_addr, 32'h0000_0100);
    wait_valid();
    chk("br_pc4", bus.if_pc_plus4, 32'h0000_0104);

    // Jump and branch together: branch wins
    step(1'b1, 1'b1, 1'b1, 32'h0000_2000);
    chk("jb_addr", bus.imem_addr, 32'h0000_2000);

    // Branch landing on the same cycle as read data
    k_lo = 2;
    k_hi = 2;
    wait_valid();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_3000);
    chk("brv_addr",  bus.imem_addr, 32'h0000_3000);
    chk("brv_valid", bus.if_valid, 1'b0);
    wait_valid();

    // PC wraparound at the top of the address space
    k_lo = 1;
    k_hi = 1;
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    wait_valid();
    chk("wrap_pc4",  bus.if_pc_plus4, 32'h0);
    chk("wrap_addr", bus.imem_addr, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);

    // Asynchronous reset while a request is outstanding
    k_lo = 4;
    k_hi = 4;
    wait_valid();
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("rstw_busy", {31'h0, m_busy}, 32'h1);
    apply_reset();

    // Randomized traffic
    k_lo = 1;
    k_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 15) == 0,
           $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
